// File: rtl/nios_accelerometer_pkg.sv
// Shared constants for the accelerometer sampling controller: register map,
// CTRL/STATUS bit positions and the sampling FSM state encoding.
package nios_accelerometer_pkg;

  // Avalon-MM word addresses
  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrPeriod = 3'd1;
  localparam logic [2:0] AddrStatus = 3'd2;
  localparam logic [2:0] AddrData   = 3'd3;
  localparam logic [2:0] AddrThresh = 3'd4;

  // CTRL bits
  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;
  localparam int unsigned CtrlFlushBit  = 2;

  // STATUS bits
  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusLevelLsb = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/nios_accelerometer_sample_fifo.sv
// Synchronous sample FIFO with show-ahead head, flush and saturating level.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module nios_accelerometer_sample_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned DepthLg2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                flush_i,
  input  logic [Width-1:0]    data_i,
  output logic [Width-1:0]    data_o,
  output logic [DepthLg2:0]   level_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned Depth = 1 << DepthLg2;
  localparam int unsigned LvlW  = DepthLg2 + 1;
  localparam logic [LvlW-1:0]     FullLevel = LvlW'(Depth);
  localparam logic [LvlW-1:0]     LvlOne    = LvlW'(1);
  localparam logic [DepthLg2-1:0] PtrOne    = DepthLg2'(1);

  logic [Width-1:0]    mem_q [Depth];
  logic [DepthLg2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q;
  logic                do_push, do_pop;

  // Flush overrides both ports so a coincident sample is discarded.
  always_comb begin
    empty_o = (level_q == '0);
    full_o  = (level_q == FullLevel);
    do_pop  = pop_i && !empty_o && !flush_i;
    do_push = push_i && (!full_o || do_pop) && !flush_i;
    data_o  = mem_q[rd_ptr_q];
    level_o = level_q;
  end

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and level bookkeeping; pointers wrap naturally at Depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlOne;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LvlOne;
      end
    end
  end

endmodule

// File: rtl/nios_accelerometer_sample_ctrl.sv
// Periodic accelerometer sampler: a programmable countdown captures in_port into a
// sample FIFO which the Nios II drains over Avalon-MM, with a level-threshold irq.
module nios_accelerometer_sample_ctrl
  import nios_accelerometer_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH_LG2 = 4,
  parameter int unsigned PERIOD_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  localparam int unsigned LvlW = DEPTH_LG2 + 1;
  localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);
  localparam logic [LvlW-1:0]     ThreshOne = LvlW'(1);

  logic                enable_q, irq_en_q, ovf_q, irq_q;
  logic [PERIOD_W-1:0] period_q, cnt_q;
  logic [LvlW-1:0]     thresh_q;
  logic [31:0]         rdata_q, rdata_d;
  state_e              state_q;

  logic                wr_ctrl, wr_period, wr_status, wr_thresh;
  logic                flush, pop, capture, drop;
  logic [PERIOD_W-1:0] reload;
  logic [LvlW-1:0]     thresh_eff;
  logic [DATA_W-1:0]   head;
  logic [LvlW-1:0]     level;
  logic                full, empty;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  // Bus decode and derived controls; zero PERIOD/THRESH behave as one.
  always_comb begin
    wr_ctrl    = write && (address == AddrCtrl);
    wr_period  = write && (address == AddrPeriod);
    wr_status  = write && (address == AddrStatus);
    wr_thresh  = write && (address == AddrThresh);
    flush      = wr_ctrl && writedata[CtrlFlushBit];
    pop        = read && (address == AddrData);
    reload     = ((period_q == '0) ? PeriodOne : period_q) - PeriodOne;
    thresh_eff = (thresh_q == '0) ? ThreshOne : thresh_q;
    capture    = (state_q == StRun) && enable_q && (cnt_q == '0);
    // A pop while full frees the slot, so only an unmatched push is lost.
    drop       = capture && full && !pop && !flush;
  end

  nios_accelerometer_sample_fifo #(
    .Width    (DATA_W),
    .DepthLg2 (DEPTH_LG2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (capture),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (in_port),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Sampling FSM; the counter freezes in idle and is reloaded on every entry to run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_q) begin
            state_q <= StRun;
            cnt_q   <= reload;
          end
        end
        StRun: begin
          if (!enable_q) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            cnt_q <= reload;
          end else begin
            cnt_q <= cnt_q - PeriodOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Software-visible configuration and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= PeriodOne;
      thresh_q <= ThreshOne;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= writedata[CtrlEnableBit];
        irq_en_q <= writedata[CtrlIrqEnBit];
      end
      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      if (wr_thresh) thresh_q <= writedata[LvlW-1:0];
      // A fresh overflow wins over a simultaneous clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (wr_status && writedata[StatusOvfBit]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Read mux; a DATA read that coincides with a flush returns zero.
  always_comb begin
    rdata_d = '0;
    case (address)
      AddrCtrl: begin
        rdata_d[CtrlEnableBit] = enable_q;
        rdata_d[CtrlIrqEnBit]  = irq_en_q;
      end
      AddrPeriod: rdata_d = 32'(period_q);
      AddrStatus: begin
        rdata_d[StatusEmptyBit]              = empty;
        rdata_d[StatusFullBit]               = full;
        rdata_d[StatusOvfBit]                = ovf_q;
        rdata_d[StatusLevelLsb +: LvlW]      = level;
      end
      AddrData: begin
        if (!empty && !flush) rdata_d = 32'(head);
      end
      AddrThresh: rdata_d = 32'(thresh_q);
      default: rdata_d = '0;
    endcase
  end

  // Registered read data and interrupt; irq follows level one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (read) rdata_q <= rdata_d;
      irq_q <= irq_en_q && (level >= thresh_eff);
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_accelerometer_sample_ctrl.sv
// Randomized and directed bench for the accelerometer sampling controller, checked
// every cycle against a queue-based model of the register/FIFO behaviour.
module tb_nios_accelerometer_sample_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  nios_accelerometer_sample_ctrl #(
    .DATA_W    (32),
    .DEPTH_LG2 (4),
    .PERIOD_W  (24)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic        m_en = 0, m_irqen = 0, m_ovf = 0, m_run = 0, m_irq = 0;
  logic [23:0] m_period = 24'd1;
  logic [4:0]  m_thresh = 5'd1;
  logic [31:0] m_rdata = 0;
  logic [31:0] mq[$];
  int          now = 0;
  int          m_next = 0;

  task automatic model_reset();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_run = 0; m_irq = 0;
    m_period = 24'd1; m_thresh = 5'd1; m_rdata = 0; mq.delete();
  endtask

  task automatic model_step();
    int lvl, per, thr;
    logic flush, pop, cap, drop;
    lvl   = mq.size();
    per   = (m_period == 0) ? 1 : int'(m_period);
    thr   = (m_thresh == 0) ? 1 : int'(m_thresh);
    flush = write && (address == 3'd0) && writedata[2];
    now++;
    if (read) begin
      case (address)
        3'd0: m_rdata = (m_irqen ? 2 : 0) + (m_en ? 1 : 0);
        3'd1: m_rdata = 32'(m_period);
        3'd2: m_rdata = 32'(lvl * 256 + (m_ovf ? 4 : 0) + (lvl == 16 ? 2 : 0) + (lvl == 0 ? 1 : 0));
        3'd3: m_rdata = (lvl > 0 && !flush) ? mq[0] : 32'd0;
        3'd4: m_rdata = 32'(m_thresh);
        default: m_rdata = 0;
      endcase
    end
    // Sampling schedule: one sample every PERIOD cycles after entering run.
    cap = 0;
    if (!m_run) begin
      if (m_en) begin
        m_run  = 1;
        m_next = now + per;
      end
    end else if (!m_en) begin
      m_run = 0;
    end else if (now == m_next) begin
      cap    = 1;
      m_next = now + per;
    end
    pop  = read && (address == 3'd3) && (lvl > 0) && !flush;
    drop = 0;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (lvl < 16 || pop) mq.push_back(in_port);
        else drop = 1;
      end
    end
    if (drop) m_ovf = 1;
    else if (write && address == 3'd2 && writedata[2]) m_ovf = 0;
    m_irq = m_irqen && (lvl >= thr);
    if (write) begin
      case (address)
        3'd0: begin m_en = writedata[0]; m_irqen = writedata[1]; end
        3'd1: m_period = writedata[23:0];
        3'd4: m_thresh = writedata[4:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("readdata_vs_model", readdata, m_rdata);
        chk("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic rnd_mode = 0;

  // Sample source: a +1 ramp (predictable captures) or random words.
  initial begin
    forever begin
      @(negedge clk);
      in_port = rnd_mode ? $urandom : in_port + 32'd1;
    end
  end

  task automatic bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    read = r; write = w; address = a; writedata = d;
    @(posedge clk);
    #1;
    read = 0; write = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus(1'b1, 1'b0, a, 32'd0);
    chk(name, readdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] v;
  logic [31:0] wd;
  logic [2:0]  ra;
  int          rw;

  initial begin
    reset_n = 0; read = 0; write = 0; address = 0; writedata = 0; in_port = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // 1: reset values
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    rd_chk("reset_ctrl", 3'd0, 32'd0);
    rd_chk("reset_period", 3'd1, 32'd1);
    rd_chk("reset_status", 3'd2, 32'h1);
    rd_chk("reset_data", 3'd3, 32'd0);
    rd_chk("reset_thresh", 3'd4, 32'd1);

    // 2: PERIOD=4 ramp capture
    bus(0, 1, 3'd1, 32'd4);
    bus(0, 1, 3'd0, 32'd1);
    v = in_port;
    idle(13);
    bus(0, 1, 3'd0, 32'd0);
    rd_chk("p4_status", 3'd2, 32'h300);
    rd_chk("p4_sample0", 3'd3, v + 32'd5);
    rd_chk("p4_sample1", 3'd3, v + 32'd9);
    rd_chk("p4_sample2", 3'd3, v + 32'd13);
    rd_chk("p4_empty", 3'd2, 32'h1);

    // 3: fill to overflow, then clear the sticky flag
    bus(0, 1, 3'd1, 32'd1);
    bus(0, 1, 3'd0, 32'd1);
    idle(20);
    bus(0, 1, 3'd0, 32'd0);
    rd_chk("full_ovf_status", 3'd2, 32'h1006);
    bus(0, 1, 3'd2, 32'h4);
    rd_chk("ovf_cleared", 3'd2, 32'h1002);

    // 5: pop coincident with capture while full
    bus(0, 1, 3'd1, 32'd3);
    bus(0, 1, 3'd0, 32'd1);
    idle(3);
    bus(1, 0, 3'd3, 32'd0);
    bus(0, 1, 3'd0, 32'd0);
    rd_chk("full_pop_push", 3'd2, 32'h1002);

    // 4: threshold interrupt
    bus(0, 1, 3'd0, 32'h4);
    rd_chk("flushed", 3'd2, 32'h1);
    bus(0, 1, 3'd4, 32'd3);
    bus(0, 1, 3'd1, 32'd2);
    bus(0, 1, 3'd0, 32'd3);
    v = in_port;
    idle(7);
    chk("irq_before_3rd", {31'd0, irq}, 32'd0);
    bus(0, 1, 3'd0, 32'd2);
    chk("irq_after_3rd", {31'd0, irq}, 32'd1);
    bus(1, 0, 3'd3, 32'd0);
    chk("irq_first_sample", readdata, v + 32'd3);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    idle(1);
    chk("irq_fall", {31'd0, irq}, 32'd0);

    // 6: flush coincident with capture, then async reset mid-run
    bus(0, 1, 3'd4, 32'd1);
    bus(0, 1, 3'd0, 32'h4);
    bus(0, 1, 3'd1, 32'd2);
    bus(0, 1, 3'd0, 32'd3);
    idle(2);
    bus(0, 1, 3'd0, 32'd7);
    rd_chk("flush_capture", 3'd2, 32'h1);
    idle(4);
    chk("irq_run", {31'd0, irq}, 32'd1);
    rd_chk("run_level2", 3'd2, 32'h200);
    #3 reset_n = 0;
    #1;
    chk("async_rst_readdata", readdata, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1;
    rd_chk("post_rst_status", 3'd2, 32'h1);
    rd_chk("post_rst_ctrl", 3'd0, 32'd0);

    // Random traffic against the model
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = $urandom_range(0, 3);
      wd = $urandom;
      if (ra == 3'd0) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[2] = ($urandom_range(0, 15) == 0);
      end
      if (ra == 3'd1) wd = $urandom_range(0, 5);
      if (ra == 3'd4) wd = $urandom_range(0, 20);
      bus(rw[0], rw[1], ra, wd);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
